wb_master_seq: RTL and testbench
================================

WB_MASTER_SEQ -- requirements
Module: wb_master_seq

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 16, meaning the number of cycles to wait for acknowledge before aborting (legal range 2..255).
REQ-002 SHALL have port i_wb_clk, input, 1 bit: the only clock; all logic is on the rising edge.
REQ-003 SHALL have port i_wb_rst, input, 1 bit: synchronous, active-high reset.
REQ-004 SHALL have port i_cmd_valid, input, 1 bit: the command request.
REQ-005 SHALL have port o_cmd_ready, output, 1 bit: the block can accept a command.
REQ-006 SHALL have port i_cmd_we, input, 1 bit: 1 = write, 0 = read.
REQ-007 SHALL have port i_cmd_addr, input, 32 bits: the bus address.
REQ-008 SHALL have port i_cmd_wdata, input, 32 bits: the write data.
REQ-009 SHALL have port i_cmd_sel, input, 4 bits: the byte lane selects.
REQ-010 SHALL have port o_rsp_valid, output, 1 bit: a one-cycle response strobe.
REQ-011 SHALL have port o_rsp_rdata, output, 32 bits: the read data.
REQ-012 SHALL have port o_rsp_err, output, 1 bit: the transaction timed out.
REQ-013 SHALL have outputs o_wb_cyc, o_wb_stb and o_wb_we, 1 bit each; o_wb_addr, 32 bits; o_wb_data, 32 bits; o_wb_sel, 4 bits: the Wishbone classic initiator signals.
REQ-014 SHALL have input i_wb_ack, 1 bit, and input i_wb_data, 32 bits: the responder acknowledge and read data.

Function
REQ-015 SHALL implement an FSM with states IDLE, BUS and RESP; o_cmd_ready = 1 only in IDLE.
REQ-016 SHALL treat i_cmd_valid & o_cmd_ready in cycle N as acceptance:
- latch we, addr, wdata and sel;
- go to BUS;
- assert o_wb_cyc = o_wb_stb = 1 from cycle N+1.
REQ-017 SHALL hold o_wb_addr, o_wb_data, o_wb_we and o_wb_sel stable for the entire BUS state.
REQ-018 SHALL drive o_wb_data = 0 for reads.
REQ-019 SHALL, on i_wb_ack = 1 in BUS at cycle M:
- capture i_wb_data when reading;
- deassert cyc/stb at M+1;
- enter RESP.
REQ-020 SHALL, in RESP, pulse o_rsp_valid for exactly one cycle (cycle M+1), then return to IDLE, so o_cmd_ready = 1 at M+2.
REQ-021 SHALL set o_rsp_rdata to the captured data for reads and to 0 for writes; o_rsp_rdata SHALL hold its value until the next response.
REQ-022 SHALL ignore i_wb_ack outside BUS.
REQ-023 SHALL leave pending i_cmd_valid unaccepted until IDLE (back-to-back minimum 3 cycles per transaction).
REQ-024 SHALL count cycles in BUS with an 8-bit counter cleared on entry (see REQ-031/032 for timeout behaviour).
REQ-025 SHALL give ack priority if ack arrives in the same cycle the timeout is reached: the response is a success with o_rsp_err = 0.

Reset
REQ-026 SHALL, while i_wb_rst = 1 at a clock edge, enter IDLE and clear the timeout counter.
REQ-027 SHALL, while in reset, drive o_wb_cyc, o_wb_stb, o_wb_we, o_rsp_valid and o_rsp_err to 0, and o_wb_addr, o_wb_data, o_wb_sel and o_rsp_rdata to 0.
REQ-028 SHALL, on reset mid-transaction, drop cyc/stb at the next edge with no response emitted.
REQ-029 SHALL give o_cmd_ready = 1 in the first cycle after reset deasserts.
REQ-030 SHALL give reset priority over every other event.

Configuration
REQ-031 SHALL, with macro WB_MASTER_TIMEOUT_EN defined, abort the transaction when the counter reaches TIMEOUT_CYCLES without ack:
- deassert cyc/stb next cycle;
- enter RESP with o_rsp_err = 1 and o_rsp_rdata = 0.
REQ-032 SHALL, without WB_MASTER_TIMEOUT_EN, omit the counter; BUS waits for ack indefinitely and o_rsp_err is tied to 0.

Verification
REQ-033 SHALL cover a write: cmd we=1, addr=0x3000_0004, wdata=0xA5A5_0F0F, sel=0xF; ack 2 cycles after stb.
- Required: stb high for 3 cycles with stable signals, rsp_valid one pulse, err=0, rdata=0.
REQ-034 SHALL cover a read: addr=0x3000_0000, responder returns 0xDEAD_BEEF with ack in the first BUS cycle.
- Required: rsp_valid at the cycle after ack with rdata=0xDEAD_BEEF; ready again 2 cycles after ack.
REQ-035 SHALL cover a timeout, with WB_MASTER_TIMEOUT_EN defined and TIMEOUT_CYCLES=16, for a read that is never acked.
- Required: cyc/stb drop after 16 BUS cycles, rsp_valid with err=1, rdata=0; without the macro, cyc stays high for 100+ cycles.
REQ-036 SHALL cover the ack/timeout collision: ack arrives on exactly the 16th BUS cycle.
- Required: err=0 and rdata equals the bus data.
REQ-037 SHALL cover reset mid-transaction: assert i_wb_rst for 1 cycle while stb is high.
- Required: cyc/stb=0 next cycle, no rsp_valid, and a later ack is ignored.
REQ-038 SHALL cover back-to-back traffic: cmd_valid held high with 4 queued commands, single-cycle ack each.
- Required: 4 responses in order, no command accepted while not IDLE, and each accept 3 cycles apart.

Source files
------------

// File: rtl/wb_master_seq.sv
// Single-command Wishbone classic initiator: accepts one command, runs one bus cycle, returns one response.
// Optional ack timeout is built only when WB_MASTER_TIMEOUT_EN is defined; otherwise BUS waits for ack forever.
module wb_master_seq #(
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic        i_wb_clk,
    input  logic        i_wb_rst,
    input  logic        i_cmd_valid,
    output logic        o_cmd_ready,
    input  logic        i_cmd_we,
    input  logic [31:0] i_cmd_addr,
    input  logic [31:0] i_cmd_wdata,
    input  logic [3:0]  i_cmd_sel,
    output logic        o_rsp_valid,
    output logic [31:0] o_rsp_rdata,
    output logic        o_rsp_err,
    output logic        o_wb_cyc,
    output logic        o_wb_stb,
    output logic        o_wb_we,
    output logic [31:0] o_wb_addr,
    output logic [31:0] o_wb_data,
    output logic [3:0]  o_wb_sel,
    input  logic        i_wb_ack,
    input  logic [31:0] i_wb_data
);

    // state  | meaning
    // S_IDLE | ready for a command
    // S_BUS  | cyc/stb asserted, waiting for ack (or timeout)
    // S_RESP | one-cycle response strobe
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUS  = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic        w_accept;
    logic        w_ack;
    logic        w_timeout;
    logic        r_we;
    logic [31:0] r_addr;
    logic [31:0] r_data;
    logic [3:0]  r_sel;
    logic [31:0] r_rdata;

    assign w_accept = i_cmd_valid && (r_state == S_IDLE);
    assign w_ack    = i_wb_ack && (r_state == S_BUS);

`ifdef WB_MASTER_TIMEOUT_EN
    localparam logic [7:0] LP_TC = 8'(TIMEOUT_CYCLES - 1);

    logic [7:0] r_cnt;
    logic       r_err;

    // Counter holds BUS cycles already elapsed; it is zero on the first BUS cycle.
    always_ff @(posedge i_wb_clk) begin
        if (i_wb_rst) begin
            r_cnt <= 8'd0;
        end else if (r_state != S_BUS) begin
            r_cnt <= 8'd0;
        end else begin
            r_cnt <= r_cnt + 8'd1;
        end
    end

    // Ack in the terminal cycle wins over the abort.
    assign w_timeout = (r_state == S_BUS) && !i_wb_ack && (r_cnt == LP_TC);

    always_ff @(posedge i_wb_clk) begin
        if (i_wb_rst) begin
            r_err <= 1'b0;
        end else if (w_ack) begin
            r_err <= 1'b0;
        end else if (w_timeout) begin
            r_err <= 1'b1;
        end
    end

    assign o_rsp_err = r_err;
`else
    assign w_timeout = 1'b0;
    assign o_rsp_err = 1'b0;
`endif

    always_ff @(posedge i_wb_clk) begin
        if (i_wb_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_accept) w_state_nxt = S_BUS;
            S_BUS:   if (w_ack || w_timeout) w_state_nxt = S_RESP;
            S_RESP:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge i_wb_clk) begin
        if (i_wb_rst) begin
            r_we    <= 1'b0;
            r_addr  <= 32'd0;
            r_data  <= 32'd0;
            r_sel   <= 4'd0;
            r_rdata <= 32'd0;
        end else begin
            if (w_accept) begin
                r_we   <= i_cmd_we;
                r_addr <= i_cmd_addr;
                r_data <= i_cmd_we ? i_cmd_wdata : 32'd0;
                r_sel  <= i_cmd_sel;
            end
            if (w_ack) begin
                r_rdata <= r_we ? 32'd0 : i_wb_data;
            end else if (w_timeout) begin
                r_rdata <= 32'd0;
            end
        end
    end

    assign o_cmd_ready = (r_state == S_IDLE);
    assign o_rsp_valid = (r_state == S_RESP);
    assign o_wb_cyc    = (r_state == S_BUS);
    assign o_wb_stb    = (r_state == S_BUS);
    assign o_wb_we     = r_we;
    assign o_wb_addr   = r_addr;
    assign o_wb_data   = r_data;
    assign o_wb_sel    = r_sel;
    assign o_rsp_rdata = r_rdata;

endmodule

// File: tb/tb_wb_master_seq.sv
// Directed plus randomized bench for wb_master_seq against a transaction-level model.
// Expectations follow WB_MASTER_TIMEOUT_EN the same way the design build does.
module tb_wb_master_seq;

    localparam int TO = 16;
`ifdef WB_MASTER_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic        clk;
    logic        i_wb_rst;
    logic        i_cmd_valid;
    logic        o_cmd_ready;
    logic        i_cmd_we;
    logic [31:0] i_cmd_addr;
    logic [31:0] i_cmd_wdata;
    logic [3:0]  i_cmd_sel;
    logic        o_rsp_valid;
    logic [31:0] o_rsp_rdata;
    logic        o_rsp_err;
    logic        o_wb_cyc;
    logic        o_wb_stb;
    logic        o_wb_we;
    logic [31:0] o_wb_addr;
    logic [31:0] o_wb_data;
    logic [3:0]  o_wb_sel;
    logic        i_wb_ack;
    logic [31:0] i_wb_data;

    int n_vec = 0;
    int n_err = 0;

    wb_master_seq #(.TIMEOUT_CYCLES(TO)) dut (
        .i_wb_clk   (clk),
        .i_wb_rst   (i_wb_rst),
        .i_cmd_valid(i_cmd_valid),
        .o_cmd_ready(o_cmd_ready),
        .i_cmd_we   (i_cmd_we),
        .i_cmd_addr (i_cmd_addr),
        .i_cmd_wdata(i_cmd_wdata),
        .i_cmd_sel  (i_cmd_sel),
        .o_rsp_valid(o_rsp_valid),
        .o_rsp_rdata(o_rsp_rdata),
        .o_rsp_err  (o_rsp_err),
        .o_wb_cyc   (o_wb_cyc),
        .o_wb_stb   (o_wb_stb),
        .o_wb_we    (o_wb_we),
        .o_wb_addr  (o_wb_addr),
        .o_wb_data  (o_wb_data),
        .o_wb_sel   (o_wb_sel),
        .i_wb_ack   (i_wb_ack),
        .i_wb_data  (i_wb_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %b, expected %b", tag, obs, exp);
        end
    endtask

    // One command, responder acks after ack_delay stb cycles (0 = first BUS cycle).
    task automatic run_txn(input bit we, input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [3:0] sel, input int ack_delay, input logic [31:0] bdata);
        bit          abort;
        int          n_bus;
        logic [31:0] exp_rd;
        abort  = TO_EN && (ack_delay >= TO);
        n_bus  = abort ? TO : ack_delay + 1;
        exp_rd = (abort || we) ? 32'd0 : bdata;
        chk1("ready_before_cmd", o_cmd_ready, 1'b1);
        i_cmd_valid = 1'b1;
        i_cmd_we    = we;
        i_cmd_addr  = addr;
        i_cmd_wdata = wdata;
        i_cmd_sel   = sel;
        tick();
        i_cmd_valid = 1'b0;
        i_cmd_we    = ~we;
        i_cmd_addr  = $urandom;
        i_cmd_wdata = $urandom;
        i_cmd_sel   = 4'($urandom);
        for (int k = 0; k < n_bus; k++) begin
            chk1("bus_cyc", o_wb_cyc, 1'b1);
            chk1("bus_stb", o_wb_stb, 1'b1);
            chk1("bus_we", o_wb_we, we);
            chk("bus_addr", o_wb_addr, addr);
            chk("bus_data", o_wb_data, we ? wdata : 32'd0);
            chk("bus_sel", {28'd0, o_wb_sel}, {28'd0, sel});
            chk1("bus_rsp_valid", o_rsp_valid, 1'b0);
            chk1("bus_ready", o_cmd_ready, 1'b0);
            i_wb_ack  = !abort && (k == ack_delay);
            i_wb_data = i_wb_ack ? bdata : $urandom;
            tick();
        end
        i_wb_ack  = 1'($urandom_range(0, 1));
        i_wb_data = $urandom;
        chk1("resp_cyc", o_wb_cyc, 1'b0);
        chk1("resp_valid", o_rsp_valid, 1'b1);
        chk1("resp_err", o_rsp_err, abort);
        chk("resp_rdata", o_rsp_rdata, exp_rd);
        chk1("resp_ready", o_cmd_ready, 1'b0);
        tick();
        i_wb_ack = 1'b0;
        chk1("post_valid", o_rsp_valid, 1'b0);
        chk1("post_ready", o_cmd_ready, 1'b1);
        chk1("post_cyc", o_wb_cyc, 1'b0);
        chk("post_rdata_hold", o_rsp_rdata, exp_rd);
    endtask

    logic [31:0] qa[4];
    logic [31:0] qd[4];
    logic [31:0] qb[4];
    logic [3:0]  qs[4];
    bit          qw[4];

    initial begin
        int idx;
        int nrsp;
        int last_acc;
        int hold;
        int stray;

        i_wb_rst    = 1'b1;
        i_cmd_valid = 1'b0;
        i_cmd_we    = 1'b0;
        i_cmd_addr  = 32'd0;
        i_cmd_wdata = 32'd0;
        i_cmd_sel   = 4'd0;
        i_wb_ack    = 1'b0;
        i_wb_data   = 32'd0;
        tick();
        tick();
        chk1("rst_cyc", o_wb_cyc, 1'b0);
        chk1("rst_stb", o_wb_stb, 1'b0);
        chk1("rst_we", o_wb_we, 1'b0);
        chk("rst_addr", o_wb_addr, 32'd0);
        chk("rst_data", o_wb_data, 32'd0);
        chk("rst_sel", {28'd0, o_wb_sel}, 32'd0);
        chk1("rst_rsp_valid", o_rsp_valid, 1'b0);
        chk1("rst_rsp_err", o_rsp_err, 1'b0);
        chk("rst_rdata", o_rsp_rdata, 32'd0);
        i_wb_rst = 1'b0;
        tick();
        chk1("ready_after_rst", o_cmd_ready, 1'b1);

        // Write, ack two cycles after stb rises.
        run_txn(1'b1, 32'h3000_0004, 32'hA5A5_0F0F, 4'hF, 2, 32'h1111_2222);
        // Read, ack in the first BUS cycle.
        run_txn(1'b0, 32'h3000_0000, 32'h7777_7777, 4'hF, 0, 32'hDEAD_BEEF);
        // Ack lands on the 16th BUS cycle.
        run_txn(1'b0, 32'h3000_0010, 32'h0, 4'h3, TO - 1, 32'hCAFE_F00D);

`ifdef WB_MASTER_TIMEOUT_EN
        run_txn(1'b0, 32'h3000_0008, 32'h0, 4'hF, 1000, 32'h1234_5678);
`else
        i_cmd_valid = 1'b1;
        i_cmd_we    = 1'b0;
        i_cmd_addr  = 32'h3000_0008;
        i_cmd_sel   = 4'hF;
        tick();
        i_cmd_valid = 1'b0;
        hold  = 0;
        stray = 0;
        for (int k = 0; k < 120; k++) begin
            if (o_wb_cyc === 1'b1) hold++;
            if (o_rsp_valid !== 1'b0) stray++;
            tick();
        end
        chk("noto_cyc_hold", 32'(hold), 32'd120);
        chk("noto_no_rsp", 32'(stray), 32'd0);
        i_wb_rst = 1'b1;
        tick();
        i_wb_rst = 1'b0;
        chk1("noto_rst_cyc", o_wb_cyc, 1'b0);
        tick();
`endif

        // Reset while stb is high, then a late ack.
        i_cmd_valid = 1'b1;
        i_cmd_we    = 1'b0;
        i_cmd_addr  = 32'h3000_0020;
        i_cmd_sel   = 4'hC;
        tick();
        i_cmd_valid = 1'b0;
        tick();
        chk1("mid_stb_before", o_wb_stb, 1'b1);
        i_wb_rst = 1'b1;
        tick();
        i_wb_rst = 1'b0;
        chk1("mid_cyc", o_wb_cyc, 1'b0);
        chk1("mid_stb", o_wb_stb, 1'b0);
        chk1("mid_rsp_valid", o_rsp_valid, 1'b0);
        chk("mid_addr", o_wb_addr, 32'd0);
        chk("mid_rdata", o_rsp_rdata, 32'd0);
        chk1("mid_ready", o_cmd_ready, 1'b1);
        i_wb_ack  = 1'b1;
        i_wb_data = 32'hBAD0_BAD0;
        tick();
        i_wb_ack = 1'b0;
        stray = 0;
        for (int k = 0; k < 3; k++) begin
            if (o_rsp_valid !== 1'b0 || o_wb_cyc !== 1'b0) stray++;
            tick();
        end
        chk("late_ack_ignored", 32'(stray), 32'd0);
        chk("late_ack_rdata", o_rsp_rdata, 32'd0);

        // Four queued commands with cmd_valid held high, single-cycle acks.
        for (int i = 0; i < 4; i++) begin
            qw[i] = 1'($urandom_range(0, 1));
            qa[i] = $urandom;
            qd[i] = $urandom;
            qb[i] = $urandom;
            qs[i] = 4'($urandom);
        end
        idx      = 0;
        nrsp     = 0;
        last_acc = -1;
        for (int c = 0; c < 40; c++) begin
            i_cmd_valid = (idx < 4);
            if (idx < 4) begin
                i_cmd_we    = qw[idx];
                i_cmd_addr  = qa[idx];
                i_cmd_wdata = qd[idx];
                i_cmd_sel   = qs[idx];
            end
            i_wb_ack  = o_wb_stb;
            i_wb_data = $urandom;
            if (o_wb_stb === 1'b1 && idx > 0) begin
                i_wb_data = qb[idx-1];
                chk("b2b_addr", o_wb_addr, qa[idx-1]);
                chk("b2b_data", o_wb_data, qw[idx-1] ? qd[idx-1] : 32'd0);
            end
            if (o_rsp_valid === 1'b1 && nrsp < 4) begin
                chk("b2b_rdata", o_rsp_rdata, qw[nrsp] ? 32'd0 : qb[nrsp]);
                nrsp++;
            end
            chk1("b2b_ready_only_idle", o_cmd_ready, !(o_wb_cyc || o_rsp_valid));
            if (o_cmd_ready === 1'b1 && idx < 4) begin
                if (last_acc >= 0) chk("b2b_spacing", 32'(c - last_acc), 32'd3);
                last_acc = c;
                idx++;
            end
            tick();
        end
        i_wb_ack    = 1'b0;
        i_cmd_valid = 1'b0;
        chk("b2b_accepts", 32'(idx), 32'd4);
        chk("b2b_responses", 32'(nrsp), 32'd4);

        // Randomized traffic with stray acks while idle.
        for (int t = 0; t < 25; t++) begin
            int gap;
            gap = $urandom_range(0, 2);
            for (int g = 0; g < gap; g++) begin
                i_wb_ack = 1'($urandom_range(0, 1));
                tick();
                chk1("rand_idle_no_rsp", o_rsp_valid, 1'b0);
            end
            run_txn(1'($urandom_range(0, 1)), $urandom, $urandom, 4'($urandom),
                    $urandom_range(0, 20), $urandom);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
